axi_lite_master: RTL and testbench

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_pkg.sv | 27 ++
 rtl/axi_timeout_ctr.sv | 38 +++
 rtl/axi_lite_master.sv | 191 +++++++++++++++++++
 tb/tb_axi_lite_master.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: master FSM states, response codes and a sizing helper.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // States in which a bus transaction is outstanding and the watchdog runs.
    function automatic logic is_active(state_t s);
        return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_RESP);
    endfunction

    // Counter width able to hold the value n.
    function automatic int cnt_width(int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axi_timeout_ctr.sv
// Transaction watchdog: counts busy cycles and flags the last allowed cycle.
module axi_timeout_ctr
    import axi_lite_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = cnt_width(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master: turns one command into an AW/W/B or AR/R
// exchange and returns the result on a valid/ready response port.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RVALID,
    output logic                  RREADY
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;

    logic cnt_clear;
    logic timed_out;
    logic abort;
    logic aw_left;
    logic w_left;

    axi_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (ACLK),
        .rst    (ARESET),
        .clear  (cnt_clear),
        .en     (is_active(state_q)),
        .expired(timed_out)
    );

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        araddr_d    = araddr_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        cnt_clear   = 1'b0;
        abort       = 1'b0;
        // AW and W retire independently; each VALID stays up until its own handshake.
        aw_left     = awvalid_q && !AWREADY;
        w_left      = wvalid_q && !WREADY;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cnt_clear = 1'b1;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    awvalid_d = aw_left;
                    wvalid_d  = w_left;
                    if (!aw_left && !w_left) begin
                        state_d = WR_RESP;
                    end
                end
            end
            // A response arriving on the last allowed cycle wins over the timeout.
            WR_RESP: begin
                if (BVALID) begin
                    rsp_resp_d  = BRESP;
                    rsp_rdata_d = '0;
                    state_d     = DONE;
                end else if (timed_out) begin
                    abort = 1'b1;
                end
            end
            RD_REQ: begin
                if (timed_out) begin
                    abort = 1'b1;
                end else if (ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (RVALID) begin
                    rsp_rdata_d = RDATA;
                    rsp_resp_d  = RESP_OKAY;
                    state_d     = DONE;
                end else if (timed_out) begin
                    abort = 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            arvalid_d   = 1'b0;
            rsp_resp_d  = RESP_DECERR;
            rsp_rdata_d = '0;
            state_d     = DONE;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            araddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            araddr_q    <= araddr_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // READY/valid strobes come from state only, so no VALID follows a READY input.
    assign cmd_ready = (state_q == IDLE) && !ARESET;
    assign rsp_valid = (state_q == DONE);
    assign BREADY    = (state_q == WR_RESP);
    assign RREADY    = (state_q == RD_RESP);
    assign AWADDR    = awaddr_q;
    assign WDATA     = wdata_q;
    assign ARADDR    = araddr_q;
    assign AWVALID   = awvalid_q;
    assign WVALID    = wvalid_q;
    assign ARVALID   = arvalid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Randomized bench for axi_lite_master: behavioural six-register slave plus a
// command-level reference model of expected responses.
module tb_axi_lite_master;

    logic        ACLK, ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP;

    axi_lite_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit mapped(input logic [31:0] a);
        return (a < 32'h18) && (a[1:0] == 2'b00);
    endfunction

    // Knobs owned by the stimulus process.
    int aw_min = 0;
    bit w_zero = 0;
    bit b_block = 0;
    bit r_block = 0;
    int clr_req = 0;

    // Counters owned by the slave process (read as differences).
    int av_cycles = 0, wv_cycles = 0, b_hs = 0, proto_err = 0;

    // Behavioural slave: evaluated 1ns after each falling edge, so its READY/VALID
    // are settled before the rising edge and handshakes can be predicted here.
    initial begin
        logic [31:0] smem [6];
        int aw_wait, w_wait, ar_wait, b_wait, r_wait;
        int aw_tgt, w_tgt, ar_tgt, b_tgt, r_tgt, clr_seen;
        bit aw_got, w_got, b_pend, r_pend, p_aw, p_w, p_ar;
        logic [31:0] aw_a, w_d, p_awaddr, p_wdata, p_araddr;
        for (int i = 0; i < 6; i++) smem[i] = '0;
        {AWREADY, WREADY, ARREADY, BVALID, RVALID} = '0;
        BRESP = '0; RDATA = '0;
        {aw_wait, w_wait, ar_wait, b_wait, r_wait} = '0;
        {aw_tgt, w_tgt, ar_tgt, b_tgt, r_tgt} = '0;
        {aw_got, w_got, b_pend, r_pend, p_aw, p_w, p_ar} = '0;
        aw_a = '0; w_d = '0; p_awaddr = '0; p_wdata = '0; p_araddr = '0;
        clr_seen = 0;
        forever begin
            @(negedge ACLK); #1;
            if (ARESET || clr_seen != clr_req) begin
                clr_seen = clr_req;
                {AWREADY, WREADY, ARREADY, BVALID, RVALID} = '0;
                {aw_wait, w_wait, ar_wait, b_wait, r_wait} = '0;
                {aw_got, w_got, b_pend, r_pend, p_aw, p_w, p_ar} = '0;
            end else begin
                AWREADY = AWVALID && !aw_got && (aw_wait >= ((aw_tgt > aw_min) ? aw_tgt : aw_min));
                WREADY  = WVALID && !w_got && (w_zero || w_wait >= w_tgt);
                ARREADY = ARVALID && !r_pend && (ar_wait >= ar_tgt);
                BVALID  = b_pend && !b_block && (b_wait >= b_tgt);
                RVALID  = r_pend && !r_block && (r_wait >= r_tgt);
                if (AWVALID) av_cycles++;
                if (WVALID) wv_cycles++;
                if (p_aw && !(AWVALID && AWADDR == p_awaddr)) proto_err++;
                if (p_w && !(WVALID && WDATA == p_wdata)) proto_err++;
                if (p_ar && !(ARVALID && ARADDR == p_araddr)) proto_err++;
                p_aw = AWVALID && !AWREADY; p_awaddr = AWADDR;
                p_w  = WVALID && !WREADY;   p_wdata  = WDATA;
                p_ar = ARVALID && !ARREADY; p_araddr = ARADDR;
                if (BVALID && BREADY) begin
                    b_hs++; b_pend = 0; b_wait = 0; b_tgt = $urandom_range(0, 2);
                end else if (b_pend) b_wait++;
                if (RVALID && RREADY) begin
                    r_pend = 0; r_wait = 0; r_tgt = $urandom_range(0, 2);
                end else if (r_pend) r_wait++;
                if (AWVALID && AWREADY) begin
                    aw_got = 1; aw_a = AWADDR; aw_wait = 0; aw_tgt = $urandom_range(0, 2);
                end else if (AWVALID) aw_wait++;
                if (WVALID && WREADY) begin
                    w_got = 1; w_d = WDATA; w_wait = 0; w_tgt = $urandom_range(0, 2);
                end else if (WVALID) w_wait++;
                if (ARVALID && ARREADY) begin
                    r_pend = 1; r_wait = 0; ar_wait = 0; ar_tgt = $urandom_range(0, 2);
                    RDATA = mapped(ARADDR) ? smem[ARADDR[4:2]] : 32'hDEAD_BEEF;
                end else if (ARVALID) ar_wait++;
                if (aw_got && w_got && !b_pend) begin
                    if (mapped(aw_a)) begin smem[aw_a[4:2]] = w_d; BRESP = 2'b00; end
                    else BRESP = 2'b10;
                    b_pend = 1; aw_got = 0; w_got = 0;
                end
            end
        end
    end

    logic [31:0] exp_mem [6];
    logic [4:0]  done_axi;

    // One command end to end; expectations come from exp_mem and the response rules.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input int hold, input bit push_new, input bit exp_to, output int lat);
        logic [31:0] er, r0;
        logic [1:0]  ep, p0;
        int n, bad;
        er = '0; ep = 2'b00;
        if (exp_to) ep = 2'b11;
        else if (wr) begin
            if (mapped(addr)) exp_mem[addr[4:2]] = data;
            else ep = 2'b10;
        end else er = mapped(addr) ? exp_mem[addr[4:2]] : 32'hDEAD_BEEF;
        @(negedge ACLK);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        n = 0;
        while (!cmd_ready && n < 40) begin @(negedge ACLK); n++; end
        chk("cmd_accept", cmd_ready, 1);
        @(negedge ACLK);
        cmd_valid = 0; lat = 1;
        while (!rsp_valid && lat < 60) begin @(negedge ACLK); lat++; end
        chk("rsp_valid", rsp_valid, 1);
        lat = lat - 1;
        done_axi = {AWVALID, WVALID, BREADY, ARVALID, RREADY};
        r0 = rsp_rdata; p0 = rsp_resp; bad = 0;
        for (int i = 0; i < hold; i++) begin
            if (push_new) begin cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h8; end
            @(negedge ACLK);
            if (!rsp_valid || rsp_rdata !== r0 || rsp_resp !== p0 || cmd_ready || ARVALID || AWVALID)
                bad++;
        end
        cmd_valid = 0;
        if (hold > 0) chk("rsp_hold", bad, 0);
        rsp_ready = 1;
        @(negedge ACLK);
        rsp_ready = 0;
        chk(wr ? "wr_resp" : "rd_resp", p0, ep);
        chk(wr ? "wr_rdata" : "rd_rdata", r0, er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, n, a0, w0, b0;
        logic [31:0] addr;
        for (int i = 0; i < 6; i++) exp_mem[i] = '0;
        ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0;
        #3;
        chk("rst_ctrl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready}, 0);
        chk("rst_addr", {AWADDR, ARADDR}, 0);
        chk("rst_data", {WDATA, rsp_rdata}, 0);
        chk("rst_resp", rsp_resp, 0);
        repeat (2) @(negedge ACLK);
        ARESET = 0;
        #1 chk("ready_after_rst", cmd_ready, 1);

        // Write then read back a mapped register; then the unmapped address.
        run_txn(1, 32'h4, 32'h1234_5678, 0, 0, 0, lat);
        run_txn(0, 32'h4, 32'h0, 0, 0, 0, lat);
        run_txn(0, 32'h40, 32'h0, 0, 0, 0, lat);
        run_txn(1, 32'h40, 32'hCAFE_F00D, 0, 0, 0, lat);

        // AWREADY stalled for 5 cycles while W is taken immediately.
        aw_min = 5; w_zero = 1;
        a0 = av_cycles; w0 = wv_cycles; b0 = b_hs;
        run_txn(1, 32'h8, 32'hA5A5_0001, 0, 0, 0, lat);
        chk("aw_stall_awvalid_cycles", av_cycles - a0, 6);
        chk("aw_stall_wvalid_cycles", wv_cycles - w0, 1);
        chk("aw_stall_b_handshakes", b_hs - b0, 1);
        aw_min = 0; w_zero = 0;

        // Write response never arrives.
        b_block = 1;
        b0 = b_hs;
        run_txn(1, 32'h40, 32'h0BAD_0BAD, 0, 0, 1, lat);
        chk("timeout_latency", lat, 16);
        chk("timeout_axi_outs", done_axi, 0);
        chk("timeout_no_b", b_hs - b0, 0);
        chk("timeout_idle", cmd_ready, 1);
        b_block = 0; clr_req++;
        @(negedge ACLK);

        // Reset while waiting in RD_RESP, then a normal read.
        r_block = 1;
        @(negedge ACLK);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'hC;
        n = 0;
        while (!cmd_ready && n < 40) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        cmd_valid = 0; n = 0;
        while (!RREADY && n < 40) begin @(negedge ACLK); n++; end
        chk("in_rd_resp", RREADY, 1);
        #2 ARESET = 1;
        #1 chk("rst_mid_ctrl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready}, 0);
        chk("rst_mid_araddr", ARADDR, 0);
        r_block = 0;
        repeat (2) @(negedge ACLK);
        ARESET = 0;
        #1 chk("ready_after_mid_rst", cmd_ready, 1);
        run_txn(0, 32'h4, 32'h0, 0, 0, 0, lat);

        // Response held off for 10 cycles with a new command waiting.
        run_txn(0, 32'h8, 32'h0, 10, 1, 0, lat);

        // Randomized mix.
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 7);
            addr = (n < 6) ? 32'(n * 4) : ((n == 6) ? 32'h40 : 32'h7C);
            run_txn(1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 3), 0, 0, lat);
        end
        chk("valid_stability", proto_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
